eth_rx_uart_drain_ctrl: RTL

Read-side sequencer between the dual-clock receive FIFO and the UART debug transmitter. It pops 10-bit FIFO words of the form {frame_start, frame_end, data}, one at a time, and hands each byte to the UART with a start/busy handshake. It frames each packet with optional SOF/EOF marker bytes and keeps frame and truncation statistics. It runs entirely in the read (UART) clock domain.

---
 rtl/eth_rx_uart_drain_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_uart_drain_ctrl.sv
// eth_rx_uart_drain_ctrl
// Read-side sequencer between the dual-clock receive FIFO and the UART debug
// transmitter. Pops one 10-bit word at a time ({frame_start, frame_end, data}),
// expands it into a short byte queue (optional EOF/SOF markers + data), and
// hands each byte to the UART with a start/busy handshake. Keeps frame and
// truncation statistics and a sticky flag for an unresponsive UART.
//
// Ports:
//   clk, rst            read-domain clock, asynchronous active-high reset
//   enable              permits new FIFO pops (queued bytes drain regardless)
//   clr_stats           synchronous clear of frame_count, trunc_count, tx_timeout
//   fifo_empty          FIFO empty flag
//   fifo_dout[9:0]      FIFO word, valid one cycle after fifo_rd_en
//   fifo_rd_en          single-cycle pop strobe
//   tx_data[7:0]        byte to UART, stable while tx_start=1
//   tx_start            byte request, held until tx_busy is sampled high
//   tx_busy             UART busy
//   in_frame            SOF accepted, closing byte not yet completed
//   frame_count[15:0]   completed frames (wrapping)
//   trunc_count[7:0]    frames restarted without an end flag (saturating)
//   tx_timeout          sticky: tx_busy never rose after tx_start
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | send next queued byte, or start a pop when queue is empty
// POP       | fifo_rd_en strobe
// LATCH     | fifo_dout valid; build the byte queue for this word
// SEND      | tx_start high, waiting for tx_busy (with timeout)
// WAIT_DONE | UART accepted the byte, waiting for tx_busy to fall

module eth_rx_uart_drain_ctrl #(
    parameter logic [7:0] SOF_BYTE       = 8'h7E,
    parameter logic [7:0] EOF_BYTE       = 8'h0A,
    parameter bit         INSERT_MARKERS = 1'b1,
    parameter int         TIMEOUT_W      = 10,
    parameter int         BUSY_TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clr_stats,
    input  logic        fifo_empty,
    input  logic [9:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        in_frame,
    output logic [15:0] frame_count,
    output logic [7:0]  trunc_count,
    output logic        tx_timeout
);

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, POP, LATCH, SEND, WAIT_DONE} state_t;

    state_t state, state_nxt;

    // Worst case for one word is EOF, SOF, data, EOF (restart on a
    // one-word frame), so the queue has four slots.
    logic [7:0]           q_byte  [4];
    logic                 q_close [4];
    logic [2:0]           q_cnt;
    logic [TIMEOUT_W-1:0] to_cnt;

    logic       w_start, w_end, w_accept;
    logic [7:0] w_data;
    logic [7:0] b_byte  [4];
    logic       b_close [4];
    logic [2:0] b_cnt;

    logic timeout_hit, head_done, close_done, trunc_evt;

    assign w_start  = fifo_dout[9];
    assign w_end    = fifo_dout[8];
    assign w_data   = fifo_dout[7:0];
    assign w_accept = w_start | in_frame;

    assign trunc_evt   = (state == LATCH) && w_start && in_frame;
    assign timeout_hit = (state == SEND) && !tx_busy && (to_cnt == TO_LAST);
    assign head_done   = ((state == WAIT_DONE) && !tx_busy) || timeout_hit;
    // A dropped (timed-out) closing byte still ends the frame.
    assign close_done  = head_done && q_close[0];

    assign fifo_rd_en = (state == POP);
    assign tx_start   = (state == SEND);
    assign tx_data    = tx_start ? q_byte[0] : 8'h00;

    // Byte list for the word currently on fifo_dout. Only the final EOF (or
    // the end-flagged data byte without markers) closes a frame; the EOF
    // inserted for a truncated frame does not.
    always_comb begin
        b_byte  = '{default: 8'h00};
        b_close = '{default: 1'b0};
        b_cnt   = 3'd0;
        if (w_accept) begin
            if (INSERT_MARKERS && w_start && in_frame) begin
                b_byte[b_cnt[1:0]] = EOF_BYTE;
                b_cnt = b_cnt + 3'd1;
            end
            if (INSERT_MARKERS && w_start) begin
                b_byte[b_cnt[1:0]] = SOF_BYTE;
                b_cnt = b_cnt + 3'd1;
            end
            b_byte[b_cnt[1:0]]  = w_data;
            b_close[b_cnt[1:0]] = w_end && !INSERT_MARKERS;
            b_cnt = b_cnt + 3'd1;
            if (INSERT_MARKERS && w_end) begin
                b_byte[b_cnt[1:0]]  = EOF_BYTE;
                b_close[b_cnt[1:0]] = 1'b1;
                b_cnt = b_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (q_cnt != 3'd0) begin
                    if (!tx_busy) state_nxt = SEND;
                end else if (enable && !fifo_empty) begin
                    state_nxt = POP;
                end
            end
            POP:       state_nxt = LATCH;
            LATCH:     state_nxt = IDLE;
            SEND: begin
                if (tx_busy)          state_nxt = WAIT_DONE;
                else if (timeout_hit) state_nxt = IDLE;
            end
            WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_cnt <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                q_byte[i]  <= 8'h00;
                q_close[i] <= 1'b0;
            end
        end else if (state == LATCH) begin
            q_cnt <= b_cnt;
            for (int i = 0; i < 4; i++) begin
                q_byte[i]  <= b_byte[i];
                q_close[i] <= b_close[i];
            end
        end else if (head_done) begin
            q_cnt <= q_cnt - 3'd1;
            for (int i = 0; i < 3; i++) begin
                q_byte[i]  <= q_byte[i+1];
                q_close[i] <= q_close[i+1];
            end
            q_byte[3]  <= 8'h00;
            q_close[3] <= 1'b0;
        end
    end

    // Outside SEND the counter is held at zero, so every SEND entry starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        to_cnt <= '0;
        else if (state != SEND)         to_cnt <= '0;
        else if (!tx_busy && !timeout_hit) to_cnt <= to_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              in_frame <= 1'b0;
        else if ((state == LATCH) && w_start) in_frame <= 1'b1;
        else if (close_done)                  in_frame <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= 16'd0;
            trunc_count <= 8'd0;
            tx_timeout  <= 1'b0;
        end else if (clr_stats) begin
            frame_count <= 16'd0;
            trunc_count <= 8'd0;
            tx_timeout  <= 1'b0;
        end else begin
            if (close_done)                          frame_count <= frame_count + 16'd1;
            if (trunc_evt && (trunc_count != 8'hFF)) trunc_count <= trunc_count + 8'd1;
            if (timeout_hit)                         tx_timeout  <= 1'b1;
        end
    end

endmodule
